// File: rtl/aes_pkg.sv
// Shared types for the AES inverse-cipher control sequencer: datapath
// operation codes, controller states and the largest supported round count.
package aes_pkg;

  localparam int AES_MAX_ROUNDS = 14;

  typedef enum logic [2:0] {
    DP_NOP       = 3'd0,
    DP_INV_SHIFT = 3'd1,
    DP_INV_SUB   = 3'd2,
    DP_ADD_KEY   = 3'd3,
    DP_INV_MIX   = 3'd4
  } dp_op_e;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_KEYEXP_GO   = 4'd1,
    ST_KEYEXP_WAIT = 4'd2,
    ST_ADDK0       = 4'd3,
    ST_SHIFT       = 4'd4,
    ST_SUB         = 4'd5,
    ST_ADDK        = 4'd6,
    ST_MIX         = 4'd7,
    ST_DONE        = 4'd8
  } aes_state_e;

endpackage

// File: rtl/aes_inv_cipher_sequencer.sv
// Control FSM for the shared AES decryption round datapath: starts key
// expansion, then steps InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns per round.
module aes_inv_cipher_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int SUB_CYCLES = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       start,
  input  logic       key_ready,
  output logic       keyexp_start,
  output logic [2:0] dp_op,
  output logic       dp_we,
  output logic [3:0] key_idx,
  output logic [1:0] mix_col,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] NR       = 4'(NUM_ROUNDS);
  localparam logic [1:0] SUB_LAST = 2'(SUB_CYCLES - 1);

  aes_state_e state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [1:0] col_q, col_d;
  logic [1:0] sub_q, sub_d;

  logic       keyexp_start_q, keyexp_start_d;
  dp_op_e     dp_op_q, dp_op_d;
  logic       dp_we_q, dp_we_d;
  logic [3:0] key_idx_q, key_idx_d;
  logic [1:0] mix_col_q, mix_col_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next state and counters, then Moore outputs decoded from the next state
  // so the registered outputs line up with the cycle the state is occupied.
  always_comb begin
    state_d        = state_q;
    r_d            = r_q;
    col_d          = col_q;
    sub_d          = sub_q;
    keyexp_start_d = 1'b0;
    dp_op_d        = DP_NOP;
    dp_we_d        = 1'b0;
    key_idx_d      = key_idx_q;
    mix_col_d      = 2'd0;
    busy_d         = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_KEYEXP_GO;
          r_d     = NR;
          col_d   = 2'd0;
          sub_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // key_ready is not looked at here: it may still be high from the last block.
      ST_KEYEXP_GO: state_d = ST_KEYEXP_WAIT;
      ST_KEYEXP_WAIT: begin
        if (key_ready) state_d = ST_ADDK0;
        else           state_d = ST_KEYEXP_WAIT;
      end
      ST_ADDK0: begin
        r_d     = NR - 4'd1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sub_d   = 2'd0;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        if (sub_q == SUB_LAST) begin
          sub_d   = 2'd0;
          state_d = ST_ADDK;
        end else begin
          sub_d   = sub_q + 2'd1;
          state_d = ST_SUB;
        end
      end
      ST_ADDK: begin
        if (r_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          col_d   = 2'd0;
          state_d = ST_MIX;
        end
      end
      ST_MIX: begin
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          r_d     = r_q - 4'd1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_MIX;
        end
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
        else        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE:        busy_d = 1'b0;
      ST_KEYEXP_GO: begin
        keyexp_start_d = 1'b1;
        busy_d         = 1'b1;
      end
      ST_KEYEXP_WAIT: busy_d = 1'b1;
      ST_ADDK0: begin
        dp_op_d   = DP_ADD_KEY;
        dp_we_d   = 1'b1;
        key_idx_d = NR;
        busy_d    = 1'b1;
      end
      ST_SHIFT: begin
        dp_op_d = DP_INV_SHIFT;
        dp_we_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_SUB: begin
        dp_op_d = DP_INV_SUB;
        dp_we_d = (sub_d == SUB_LAST);
        busy_d  = 1'b1;
      end
      ST_ADDK: begin
        dp_op_d   = DP_ADD_KEY;
        dp_we_d   = 1'b1;
        key_idx_d = r_d;
        busy_d    = 1'b1;
      end
      ST_MIX: begin
        dp_op_d   = DP_INV_MIX;
        dp_we_d   = 1'b1;
        mix_col_d = col_d;
        busy_d    = 1'b1;
      end
      ST_DONE:        done_d = 1'b1;
      default:        busy_d = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= ST_IDLE;
      r_q            <= NR;
      col_q          <= 2'd0;
      sub_q          <= 2'd0;
      keyexp_start_q <= 1'b0;
      dp_op_q        <= DP_NOP;
      dp_we_q        <= 1'b0;
      key_idx_q      <= 4'd0;
      mix_col_q      <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      r_q            <= r_d;
      col_q          <= col_d;
      sub_q          <= sub_d;
      keyexp_start_q <= keyexp_start_d;
      dp_op_q        <= dp_op_d;
      dp_we_q        <= dp_we_d;
      key_idx_q      <= key_idx_d;
      mix_col_q      <= mix_col_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign keyexp_start = keyexp_start_q;
  assign dp_op        = dp_op_q;
  assign dp_we        = dp_we_q;
  assign key_idx      = key_idx_q;
  assign mix_col      = mix_col_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_sequencer.sv
// Bench for aes_inv_cipher_sequencer: two instances (InvSubBytes latency 1 and 3),
// a key-expander model, a stream monitor, a run table and hand-written corner cases.
module tb_aes_inv_cipher_sequencer;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SHIFT = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_MIX   = 3'd4;
  localparam int NR = 10;

  typedef struct {
    int inst;
    int kdly;
    bit pulse;
    int exp_we;
    int exp_lat;
    int exp_mix;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start     [2];
  logic       key_ready [2];
  logic       kes       [2];
  logic [2:0] dp_op     [2];
  logic       dp_we     [2];
  logic [3:0] key_idx   [2];
  logic [1:0] mix_col   [2];
  logic       busy      [2];
  logic       done      [2];

  always #5 clk = ~clk;

  aes_inv_cipher_sequencer #(.NUM_ROUNDS(10), .SUB_CYCLES(1)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start[0]), .key_ready(key_ready[0]),
    .keyexp_start(kes[0]), .dp_op(dp_op[0]), .dp_we(dp_we[0]), .key_idx(key_idx[0]),
    .mix_col(mix_col[0]), .busy(busy[0]), .done(done[0])
  );

  aes_inv_cipher_sequencer #(.NUM_ROUNDS(10), .SUB_CYCLES(3)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start[1]), .key_ready(key_ready[1]),
    .keyexp_start(kes[1]), .dp_op(dp_op[1]), .dp_we(dp_we[1]), .key_idx(key_idx[1]),
    .mix_col(mix_col[1]), .busy(busy[1]), .done(done[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc;
  int kdelay [2];
  int kcnt   [2];
  int we_tot [2], ke_tot [2], mix_tot [2];
  int kerr [2], mixerr [2], suberr [2], tailerr [2], operr [2];
  int ke_cyc [2], addk0_cyc [2], lat [2];
  int exp_key [2], exp_col [2], sub_run [2];
  bit in_run [2], prev_done [2];
  logic [2:0] cur_op [2], h0 [2], h1 [2], h2 [2];

  function automatic int subc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int outs(input int i);
    return int'({kes[i], dp_op[i], dp_we[i], key_idx[i], mix_col[i], busy[i], done[i]});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Key expander: drops key_ready one cycle after keyexp_start, raises it kdelay cycles after.
  initial begin
    for (int i = 0; i < 2; i++) begin
      kcnt[i]      = 0;
      key_ready[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst_n !== 1'b1) begin
          kcnt[i]      = 0;
          key_ready[i] = 1'b0;
        end else if (kes[i] === 1'b1) begin
          kcnt[i] = kdelay[i];
        end else if (kcnt[i] > 0) begin
          kcnt[i]--;
          key_ready[i] = (kcnt[i] == 0);
        end
      end
    end
  end

  // Stream monitor: tallies writes and checks op ordering against the AES round schedule.
  initial begin
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      we_tot[i] = 0; ke_tot[i] = 0; mix_tot[i] = 0;
      kerr[i] = 0; mixerr[i] = 0; suberr[i] = 0; tailerr[i] = 0; operr[i] = 0;
      ke_cyc[i] = 0; addk0_cyc[i] = 0; lat[i] = 0;
      exp_key[i] = NR; exp_col[i] = 0; sub_run[i] = 0;
      in_run[i] = 1'b0; prev_done[i] = 1'b0;
      cur_op[i] = OP_NOP; h0[i] = OP_NOP; h1[i] = OP_NOP; h2[i] = OP_NOP;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst_n !== 1'b1) begin
          in_run[i] = 1'b0; sub_run[i] = 0; prev_done[i] = 1'b0; cur_op[i] = OP_NOP;
        end else begin
          if (dp_we[i] === 1'b1) we_tot[i]++;
          if (kes[i] === 1'b1) begin
            ke_tot[i]++; ke_cyc[i] = cyc; exp_key[i] = NR; exp_col[i] = 0; in_run[i] = 1'b1;
          end
          if (dp_op[i] === OP_ADD) begin
            if (!in_run[i] || int'(key_idx[i]) != exp_key[i] || dp_we[i] !== 1'b1) kerr[i]++;
            if (exp_key[i] == NR) addk0_cyc[i] = cyc;
            exp_key[i]--;
          end
          if (dp_op[i] === OP_MIX) begin
            mix_tot[i]++;
            if (int'(mix_col[i]) != exp_col[i] || dp_we[i] !== 1'b1) mixerr[i]++;
            exp_col[i] = (exp_col[i] + 1) % 4;
          end
          if (dp_op[i] === OP_SUB) begin
            sub_run[i]++;
            if (dp_we[i] !== (sub_run[i] == subc(i))) suberr[i]++;
          end else begin
            if (sub_run[i] != 0 && sub_run[i] != subc(i)) suberr[i]++;
            sub_run[i] = 0;
          end
          if (dp_op[i] === OP_NOP && dp_we[i] !== 1'b0) operr[i]++;
          if (dp_op[i] === OP_SHIFT && dp_we[i] !== 1'b1) operr[i]++;
          if (dp_op[i] !== OP_NOP && busy[i] !== 1'b1) operr[i]++;
          if (busy[i] === 1'b1 && done[i] === 1'b1) operr[i]++;
          if (dp_op[i] !== OP_NOP && dp_op[i] !== cur_op[i]) begin
            h2[i] = h1[i]; h1[i] = h0[i]; h0[i] = dp_op[i];
          end
          cur_op[i] = dp_op[i];
          if (done[i] === 1'b1 && !prev_done[i]) begin
            lat[i] = cyc - addk0_cyc[i];
            if (!(h0[i] == OP_ADD && h1[i] == OP_SUB && h2[i] == OP_SHIFT && key_idx[i] == 4'd0))
              tailerr[i]++;
            in_run[i] = 1'b0;
          end
          prev_done[i] = (done[i] === 1'b1);
        end
      end
      cyc++;
    end
  end

  task automatic run_vec(input vec_t rv, input string tag);
    int i, we0, ke0, mx0, t;
    i = rv.inst;
    kdelay[i] = rv.kdly;
    @(negedge clk);
    we0 = we_tot[i]; ke0 = ke_tot[i]; mx0 = mix_tot[i];
    start[i] = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_rise"}, int'(busy[i]), 1);
    chk({tag, "_keyexp_go"}, int'(kes[i]), 1);
    if (rv.pulse) start[i] = 1'b0;
    @(negedge clk);
    chk({tag, "_keyexp_single"}, int'(kes[i]), 0);
    t = 0;
    while (done[i] !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, int'(t < 500), 1);
    start[i] = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_we_count"}, we_tot[i] - we0, rv.exp_we);
    chk({tag, "_keyexp_count"}, ke_tot[i] - ke0, 1);
    chk({tag, "_mix_count"}, mix_tot[i] - mx0, rv.exp_mix);
    chk({tag, "_addk0_to_done"}, lat[i], rv.exp_lat);
    chk({tag, "_key_wait"}, addk0_cyc[i] - ke_cyc[i], rv.kdly + 1);
    chk({tag, "_idle_after"}, int'({busy[i], done[i]}), 0);
    chk({tag, "_key_idx_order"}, kerr[i], 0);
    chk({tag, "_mix_col_pattern"}, mixerr[i], 0);
    chk({tag, "_sub_timing"}, suberr[i], 0);
    chk({tag, "_tail_ops"}, tailerr[i], 0);
    chk({tag, "_op_we_busy"}, operr[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [4];
    vec_t post;
    int t, n, ke0;

    vecs[0] = '{inst: 0, kdly: 5, pulse: 1'b0, exp_we: 67, exp_lat: 67, exp_mix: 36};
    vecs[1] = '{inst: 1, kdly: 5, pulse: 1'b0, exp_we: 67, exp_lat: 87, exp_mix: 36};
    vecs[2] = '{inst: 0, kdly: 3, pulse: 1'b1, exp_we: 67, exp_lat: 67, exp_mix: 36};
    vecs[3] = '{inst: 1, kdly: 2, pulse: 1'b1, exp_we: 67, exp_lat: 87, exp_mix: 36};
    post    = '{inst: 0, kdly: 3, pulse: 1'b0, exp_we: 67, exp_lat: 67, exp_mix: 36};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i]  = 1'b0;
      kdelay[i] = 5;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs_0", outs(0), 0);
    chk("reset_outputs_1", outs(1), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_without_start", outs(0) + outs(1), 0);

    // start held through DONE: no retrigger, done clears the cycle after start drops
    kdelay[1] = 4;
    @(negedge clk);
    ke0 = ke_tot[1];
    start[1] = 1'b1;
    t = 0;
    while (done[1] !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("hs_done_seen", int'(t < 500), 1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done[1] === 1'b1) n++;
    end
    chk("hs_done_hold", n, 6);
    chk("hs_no_retrigger", ke_tot[1] - ke0, 1);
    chk("hs_busy_low_in_done", int'(busy[1]), 0);
    chk("hs_tail_ops", tailerr[1], 0);
    start[1] = 1'b0;
    @(negedge clk);
    chk("hs_done_clear", int'(done[1]), 0);

    for (int v = 0; v < 4; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
    end

    // asynchronous reset in the middle of InvMixColumns, then a clean run
    kdelay[0] = 3;
    @(negedge clk);
    start[0] = 1'b1;
    t = 0;
    while (dp_op[0] !== OP_MIX && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mix_reached", int'(t < 200), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", outs(0), 0);
    start[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", outs(0), 0);
    run_vec(post, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
